// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and default widths for the multiply/divide unit
package muldiv_pkg;
  localparam int XLEN_D = 32;
  localparam int ADDR_W_D = 4;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MULHU = 2'b01, OP_DIVU = 2'b10, OP_REMU = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_e;
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request and write-back handshake bundle of the multiply/divide unit
interface muldiv_if import muldiv_pkg::*; #(parameter int XLEN = XLEN_D, parameter int ADDR_W = ADDR_W_D);
  logic start;
  logic [1:0] op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [ADDR_W-1:0] rd_in;
  logic kill;
  logic busy;
  logic wb_valid;
  logic wb_ready;
  logic [XLEN-1:0] result;
  logic [ADDR_W-1:0] rd_out;
  modport master(output start, op, rs1_data, rs2_data, rd_in, kill, wb_ready, input busy, wb_valid, result, rd_out);
  modport slave(input start, op, rs1_data, rs2_data, rd_in, kill, wb_ready, output busy, wb_valid, result, rd_out);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned MUL/MULHU/DIVU/REMU with valid/ready write-back
module muldiv_unit import muldiv_pkg::*; #(parameter int XLEN = XLEN_D, parameter int ADDR_W = ADDR_W_D) (
  input logic clk,
  input logic reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  state_e state, state_nx;
  logic [CW-1:0] count;
  logic [1:0] op_q;
  logic [XLEN-1:0] b_q;
  logic [2*XLEN-1:0] acc, acc_nx;
  logic [XLEN:0] rem, diff, sum;
  logic accept, div0, last;
  logic [XLEN-1:0] result_q;
  logic [ADDR_W-1:0] rd_q;
  assign accept = state == IDLE && bus.start && !bus.kill;
  assign div0 = bus.op inside {OP_DIVU, OP_REMU} && bus.rs2_data == '0;
  assign last = count == CW'(XLEN - 1);
  assign bus.result = result_q;
  assign bus.rd_out = rd_q;
  // one iteration: shift-add on the low bit for multiply, restoring subtract for divide
  always_comb begin
    rem = acc[2*XLEN-1:XLEN-1];
    diff = rem - {1'b0, b_q};
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
    acc_nx = op_q[1] ? (diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                     : {sum, acc[XLEN-1:1]};
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // next state: kill wins, divide by zero skips the iterations
  always_comb begin
    state_nx = bus.kill ? IDLE
             : state == IDLE ? (bus.start ? (div0 ? DONE : CALC) : IDLE)
             : state == CALC ? (last ? DONE : CALC)
             : (bus.wb_ready ? IDLE : DONE);
  end
  // status outputs decoded from state
  always_comb begin
    bus.busy = state != IDLE;
    bus.wb_valid = state == DONE;
  end
  // operand capture, iteration datapath and result load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      op_q <= '0;
      b_q <= '0;
      acc <= '0;
      result_q <= '0;
      rd_q <= '0;
    end else if (accept) begin
      count <= '0;
      op_q <= bus.op;
      b_q <= bus.op[1] ? bus.rs2_data : bus.rs1_data;
      acc <= {{XLEN{1'b0}}, bus.op[1] ? bus.rs1_data : bus.rs2_data};
      rd_q <= bus.rd_in;
      if (div0) result_q <= bus.op[0] ? bus.rs1_data : '1;
    end else if (state == CALC && !bus.kill) begin
      acc <= acc_nx;
      count <= count + CW'(1);
      if (last) result_q <= op_q[0] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic clk = 0;
  logic reset = 1;
  int n_checks = 0;
  int n_fail = 0;
  muldiv_if #(.XLEN(32), .ADDR_W(4)) bus();
  muldiv_unit #(.XLEN(32), .ADDR_W(4)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      2'b00: return p[31:0];
      2'b01: return p[63:32];
      2'b10: return b == 0 ? 32'hFFFF_FFFF : a / b;
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] rd);
    bus.start = 1; bus.op = op; bus.rs1_data = a; bus.rs2_data = b; bus.rd_in = rd;
    @(negedge clk);
    bus.start = 0; bus.rs1_data = $urandom; bus.rs2_data = $urandom; bus.rd_in = 4'($urandom); bus.op = 2'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.wb_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] rd,
                       output logic [31:0] res, output logic [3:0] rdo, output int lat);
    issue(op, a, b, rd);
    wait_valid(lat);
    res = bus.result;
    rdo = bus.rd_out;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.wb_valid, bus.result, bus.rd_out} !== 38'b0) begin
      n_fail++; $display("FAIL reset_state got busy=%b valid=%b result=%h rd=%h want all 0", bus.busy, bus.wb_valid, bus.result, bus.rd_out);
    end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] r; logic [3:0] d; int lat;
    do_op(OP_MUL, 7, 6, 5, r, d, lat);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL mul_latency got %0d want 32", lat); end
    n_checks++; if (r !== 32'd42) begin n_fail++; $display("FAIL mul_7x6 got %h want 0000002a", r); end
    n_checks++; if (d !== 4'd5) begin n_fail++; $display("FAIL mul_rd got %h want 5", d); end
    n_checks++; if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mul_idle_after got valid=%b busy=%b want 0 0", bus.wb_valid, bus.busy); end
    do_op(OP_MULHU, '1, '1, 3, r, d, lat);
    n_checks++; if (r !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_max got %h want fffffffe", r); end
    do_op(OP_MUL, '1, '1, 3, r, d, lat);
    n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL mul_max got %h want 00000001", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; logic [3:0] d; int lat;
    do_op(OP_DIVU, 100, 7, 2, r, d, lat);
    n_checks++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu_100_7 got %h want 0000000e", r); end
    do_op(OP_REMU, 100, 7, 2, r, d, lat);
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL remu_100_7 got %h want 00000002", r); end
    do_op(OP_DIVU, 5, 0, 0, r, d, lat);
    n_checks++; if (lat !== 0) begin n_fail++; $display("FAIL divu_zero_latency got %0d want 0", lat); end
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_zero got %h want ffffffff", r); end
    n_checks++; if (d !== 4'd0) begin n_fail++; $display("FAIL rd_x0 got %h want 0", d); end
    do_op(OP_REMU, 5, 0, 1, r, d, lat);
    n_checks++; if (r !== 32'd5) begin n_fail++; $display("FAIL remu_zero got %h want 00000005", r); end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] exp;
    exp = model(OP_MUL, 12345, 678);
    bus.wb_ready = 0;
    issue(OP_MUL, 12345, 678, 9);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 4);
      bus.rs1_data = 1; bus.rs2_data = 1; bus.op = OP_DIVU; bus.rd_in = 1;
      @(negedge clk);
      n_checks++;
      if (bus.wb_valid !== 1'b1 || bus.busy !== 1'b1 || bus.result !== exp || bus.rd_out !== 4'd9) begin
        n_fail++; $display("FAIL hold_%0d got valid=%b busy=%b result=%h rd=%h want 1 1 %h 9", i, bus.wb_valid, bus.busy, bus.result, bus.rd_out, exp);
      end
    end
    bus.start = 0;
    bus.wb_ready = 1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (bus.wb_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_release got valid=%b busy=%b want 0 0", bus.wb_valid, bus.busy); end
  endtask

  task automatic test_kill();
    int lat;
    logic [31:0] exp;
    issue(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 7);
    repeat (15) @(negedge clk);
    bus.kill = 1;
    @(negedge clk);
    bus.kill = 0;
    n_checks++; if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL kill_idle got busy=%b valid=%b want 0 0", bus.busy, bus.wb_valid); end
    exp = model(OP_MULHU, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    issue(OP_MULHU, 32'hDEAD_BEEF, 32'h0BAD_F00D, 11);
    wait_valid(lat);
    n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL kill_restart_latency got %0d want 32", lat); end
    n_checks++; if (bus.result !== exp || bus.rd_out !== 4'd11) begin n_fail++; $display("FAIL kill_restart got %h rd=%h want %h rd=b", bus.result, bus.rd_out, exp); end
    @(negedge clk);
    bus.kill = 1;
    bus.start = 1;
    @(negedge clk);
    bus.kill = 0;
    bus.start = 0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL kill_start_priority got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r; logic [3:0] d; int lat;
    issue(OP_DIVU, 32'hF000_0000, 7, 6);
    repeat (10) @(negedge clk);
    #2 reset = 1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0 || bus.result !== 32'b0 || bus.rd_out !== 4'b0) begin
      n_fail++; $display("FAIL async_reset got busy=%b valid=%b result=%h rd=%h want all 0", bus.busy, bus.wb_valid, bus.result, bus.rd_out);
    end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    do_op(OP_DIVU, 9, 3, 4, r, d, lat);
    n_checks++; if (r !== 32'd3) begin n_fail++; $display("FAIL divu_9_3 got %h want 00000003", r); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, exp; logic [3:0] rd, d; logic [1:0] op; int lat, exp_lat;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      rd = 4'($urandom);
      exp = model(op, a, b);
      exp_lat = (op[1] && b == 0) ? 0 : 32;
      do_op(op, a, b, rd, r, d, lat);
      n_checks++;
      if (r !== exp || d !== rd || lat !== exp_lat) begin
        n_fail++; $display("FAIL random_%0d op=%0d a=%h b=%h got %h rd=%h lat=%0d want %h rd=%h lat=%0d", i, op, a, b, r, d, lat, exp, rd, exp_lat);
      end
    end
  endtask

  initial begin
    bus.start = 0; bus.kill = 0; bus.wb_ready = 1; bus.op = 0;
    bus.rs1_data = 0; bus.rs2_data = 0; bus.rd_in = 0;
    test_reset();
    test_mul();
    test_div();
    test_backpressure();
    test_kill();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
